// File: rtl/div_pkg.sv
// Shared types and constants for the 10-by-5 divider controller.
// Optional DIV_RESTORING_EN selects the restoring flow (SUB/REST states).
package div_pkg;

  localparam int unsigned DivN    = 5;
  localparam int unsigned DivCntW = 3;

  // Cycles from start to done for the two algorithms
  localparam int unsigned LAT_NR = 16;
  localparam int unsigned LAT_R  = 20;

  typedef enum logic [3:0] {
    StIdle,
    StLdd,
    StChk,
    StShift,
    StAdd,
    StSub,
    StRest,
    StLast,
    StCorr,
    StOutq,
    StOutr,
    StErrDz,
    StErrOv
  } div_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Control FSM for the 10-bit by 5-bit divider datapath (non-restoring by default).
// Define DIV_RESTORING_EN to build the restoring variant instead.
module div_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N     = DivN,
  parameter int unsigned CNT_W = DivCntW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sign,
  input  logic or_d,
  input  logic OV_not,
  output logic ldd,
  output logic ldw,
  output logic shw,
  output logic ldq,
  output logic shq,
  output logic q0,
  output logic d_sel,
  output logic w_sel,
  output logic out_sel,
  output logic busy,
  output logic done,
  output logic q_valid,
  output logic r_valid,
  output logic err_dz,
  output logic err_ov
);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cnt_first, cnt_last;

  assign cnt_first = (cnt_q == '0);
  assign cnt_last  = (cnt_q == CNT_W'(N - 1));

`ifdef DIV_RESTORING_EN
  logic qb_q, qb_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qb_q    <= qb_d;
    end
  end
`else
  logic sgn_q, sgn_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
    end
  end
`endif

  assign busy = rst_n && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DIV_RESTORING_EN
    qb_d    = qb_q;
`else
    sgn_d   = sgn_q;
`endif
    ldd     = 1'b0;
    ldw     = 1'b0;
    shw     = 1'b0;
    ldq     = 1'b0;
    shq     = 1'b0;
    q0      = 1'b0;
    d_sel   = 1'b0;
    w_sel   = 1'b0;
    out_sel = 1'b0;
    done    = 1'b0;
    q_valid = 1'b0;
    r_valid = 1'b0;
    err_dz  = 1'b0;
    err_ov  = 1'b0;

    // Outputs stay quiet while reset is held, even before the state register clears
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ldw     = 1'b1;
            w_sel   = 1'b1;
            ldq     = 1'b1;
            state_d = StLdd;
          end
        end
        StLdd: begin
          ldd     = 1'b1;
          state_d = or_d ? StChk : StErrDz;
        end
        StChk: begin
          if (!OV_not) begin
            state_d = StErrOv;
          end else begin
            cnt_d   = '0;
            state_d = StShift;
          end
        end
`ifdef DIV_RESTORING_EN
        StShift: begin
          shw     = 1'b1;
          shq     = 1'b1;
          q0      = cnt_first ? 1'b0 : qb_q;
          state_d = StSub;
        end
        StSub: begin
          ldw     = 1'b1;
          d_sel   = 1'b1;
          state_d = StRest;
        end
        StRest: begin
          qb_d  = ~sign;
          if (sign) begin
            ldw = 1'b1;
          end
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = cnt_last ? StLast : StShift;
        end
        StLast: begin
          shq     = 1'b1;
          q0      = qb_q;
          state_d = StOutq;
        end
`else
        StShift: begin
          shw     = 1'b1;
          shq     = 1'b1;
          // First shift pushes a junk bit into Q; it falls out again in StLast
          q0      = cnt_first ? 1'b0 : ~sign;
          sgn_d   = sign;
          state_d = StAdd;
        end
        StAdd: begin
          // W may wrap after the shift, so use the sign captured before it
          ldw     = 1'b1;
          d_sel   = ~sgn_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = cnt_last ? StLast : StShift;
        end
        StLast: begin
          shq     = 1'b1;
          q0      = ~sign;
          state_d = StCorr;
        end
        StCorr: begin
          if (sign) begin
            ldw = 1'b1;
          end
          state_d = StOutq;
        end
`endif
        StOutq: begin
          q_valid = 1'b1;
          state_d = StOutr;
        end
        StOutr: begin
          out_sel = 1'b1;
          r_valid = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
        StErrDz: begin
          err_dz  = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
        StErrOv: begin
          err_ov  = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl driving a behavioural divider datapath; results are scored
// against plain integer division in a queue-based scoreboard.
module tb_div_ctrl;
  import div_pkg::*;

`ifdef DIV_RESTORING_EN
  localparam int unsigned Lat = LAT_R;
`else
  localparam int unsigned Lat = LAT_NR;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [9:0] data_in;
  logic sign, or_d, OV_not;
  logic ldd, ldw, shw, ldq, shq, q0, d_sel, w_sel, out_sel;
  logic busy, done, q_valid, r_valid, err_dz, err_ov;
  logic [14:0] outs;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .sign    (sign),
    .or_d    (or_d),
    .OV_not  (OV_not),
    .ldd     (ldd),
    .ldw     (ldw),
    .shw     (shw),
    .ldq     (ldq),
    .shq     (shq),
    .q0      (q0),
    .d_sel   (d_sel),
    .w_sel   (w_sel),
    .out_sel (out_sel),
    .busy    (busy),
    .done    (done),
    .q_valid (q_valid),
    .r_valid (r_valid),
    .err_dz  (err_dz),
    .err_ov  (err_ov)
  );

  assign outs = {ldd, ldw, shw, ldq, shq, q0, d_sel, w_sel, out_sel,
                 busy, done, q_valid, r_valid, err_dz, err_ov};

  // Behavioural datapath: W (6b), Q (5b), D (5b)
  logic [5:0] w_r;
  logic [4:0] q_r, d_r;
  logic [4:0] data_out;

  always_ff @(posedge clk) begin
    if (ldd) d_r <= data_in[4:0];
    if (ldw) w_r <= w_sel ? {1'b0, data_in[9:5]}
                          : (d_sel ? w_r - {1'b0, d_r} : w_r + {1'b0, d_r});
    else if (shw) w_r <= {w_r[4:0], q_r[4]};
    if (ldq) q_r <= data_in[4:0];
    else if (shq) q_r <= {q_r[3:0], q0};
  end

  assign sign     = w_r[5];
  assign or_d     = |data_in;
  assign OV_not   = (w_r < {1'b0, d_r});
  assign data_out = out_sel ? w_r[4:0] : q_r;

  // Scoreboard
  typedef struct {
    int unsigned q;
    int unsigned r;
    bit          dz;
    bit          ov;
    int unsigned t0;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          qv_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned t0);
    exp_t e;
    e.t0 = t0;
    e.dz = (b == 0);
    e.ov = !e.dz && ((a / b) > 31);
    e.q  = e.dz ? 0 : a / b;
    e.r  = e.dz ? 0 : a % b;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if ((err_dz || err_ov) && !done) chk("err_without_done", 1, 0);
      if (q_valid) begin
        if (sb.size() == 0) begin
          chk("q_valid_unexpected", 1, 0);
        end else begin
          e = sb[0];
          qv_seen = 1'b1;
          chk("q_valid_on_error_op", e.dz || e.ov, 0);
          chk("q_latency", cyc - e.t0, Lat - 1);
          chk("quotient", data_out, e.q);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc - e.t0, e.dz ? 2 : (e.ov ? 3 : Lat));
          chk("err_dz", err_dz, e.dz);
          chk("err_ov", err_ov, e.ov);
          chk("r_valid", r_valid, !(e.dz || e.ov));
          chk("q_valid_seen", qv_seen, !(e.dz || e.ov));
          if (!(e.dz || e.ov)) chk("remainder", data_out, e.r);
        end
        qv_seen = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [9:0] a, input logic [4:0] b, input bit spur,
                        input bit corr);
    exp_t        e;
    int unsigned rel;
    @(posedge clk); #1;
    start   = 1'b1;
    data_in = a;
    e = model(a, b, cyc);
    sb.push_back(e);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      rel     = cyc - e.t0;
      start   = spur && (rel == 5 || rel == 6);
      data_in = (rel == 1) ? {5'b0, b} : 10'($urandom);
      if (corr && rel == 14) chk("corr_restore_ldw", ldw, 1);
      if (sb.size() == 0) break;
    end
    chk("op_completed", sb.size(), 0);
    sb.delete();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  a;
    logic [4:0]  b;
    int unsigned t0;
    int unsigned done_cnt;

    rst_n   = 1'b0;
    start   = 1'b1;
    data_in = 10'd100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("outs_during_reset", outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("outs_after_reset", outs, 0);

    run_op(10'd100, 5'd7, 1'b0, 1'b0);
`ifdef DIV_RESTORING_EN
    run_op(10'd5, 5'd7, 1'b0, 1'b0);
`else
    run_op(10'd5, 5'd7, 1'b0, 1'b1);
`endif
    run_op(10'd961, 5'd31, 1'b0, 1'b0);
    run_op(10'd1000, 5'd31, 1'b0, 1'b0);
    run_op(10'd100, 5'd0, 1'b0, 1'b0);
    run_op(10'd100, 5'd7, 1'b1, 1'b0);

    // Abort mid-operation with reset: no done may follow
    @(posedge clk); #1;
    start   = 1'b1;
    data_in = 10'd100;
    t0      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = 10'd7;
    while (cyc - t0 < 8) begin
      @(posedge clk); #1;
      data_in = 10'($urandom);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("outs_mid_reset", outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("outs_after_abort", outs, 0);
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    run_op(10'd100, 5'd7, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      b = 5'($urandom_range(0, 31));
      if (i % 8 == 0) b = 5'd0;
      if (b != 0 && ($urandom % 4) != 0) a = 10'($urandom_range(0, 32 * int'(b) - 1));
      else a = 10'($urandom);
      run_op(a, b, ($urandom % 3) == 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
